// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light controller and its lamp monitor:
// phase encodings, monitor error codes, default phase durations and helpers.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_YELLOW = 2'd1,
        PH_GREEN  = 2'd2,
        PH_NONE   = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_ONEHOT = 3'd1,
        ERR_ORDER  = 3'd2,
        ERR_SHORT  = 3'd3,
        ERR_LONG   = 3'd4
    } err_code_e;

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_TRACK  = 1'b1
    } mon_state_e;

    localparam int DEF_RED_CYC    = 30;
    localparam int DEF_YELLOW_CYC = 5;
    localparam int DEF_GREEN_CYC  = 20;

    // Legal successor in the RED -> YELLOW -> GREEN -> RED rotation.
    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_RED:    nxt = PH_YELLOW;
            PH_YELLOW: nxt = PH_GREEN;
            PH_GREEN:  nxt = PH_RED;
            default:   nxt = PH_NONE;
        endcase
        return nxt;
    endfunction

    // True when exactly one of the three lamps is lit.
    function automatic logic lamps_onehot(input logic red, input logic yellow, input logic green);
        logic [2:0] lamps;
        lamps = {red, yellow, green};
        return (lamps == 3'b100) || (lamps == 3'b010) || (lamps == 3'b001);
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase duration counter for the lamp monitor. Counts consecutive samples of
// the current phase (saturating) and flags SHORT/LONG against the expected
// duration. A phase whose start was not observed (partial) is never judged.
module tl_phase_timer #(
    parameter int DUR_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,          // new phase begins, duration becomes 1
    input  logic             start_partial,  // the phase being started had an unseen beginning
    input  logic             hold,           // same phase sampled again
    input  logic             clear,          // tracking lost, duration back to 0
    input  logic [DUR_W-1:0] exp_cyc,        // expected duration of the current phase
    output logic             short_flag,     // current phase ended too early
    output logic             long_flag       // this sample makes the phase one too long
);

    localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};
    localparam logic [DUR_W-1:0] DUR_ONE = {{(DUR_W-1){1'b0}}, 1'b1};

    logic [DUR_W-1:0] dur_r;
    logic             partial_r;
    logic [DUR_W-1:0] dur_inc_s;

    // Saturating increment and the duration compares.
    always_comb begin
        dur_inc_s = dur_r;
        if (dur_r == DUR_MAX) begin
            dur_inc_s = dur_r;
        end else begin
            dur_inc_s = dur_r + DUR_ONE;
        end
        short_flag = !partial_r && (dur_r < exp_cyc);
        // Incremented value equals exp+1 exactly when the current count equals
        // exp and is not saturated; a saturated counter never re-flags.
        long_flag  = hold && !partial_r && (dur_r == exp_cyc) && (dur_r != DUR_MAX);
    end

    // Duration counter and partial-phase flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dur_r     <= {DUR_W{1'b0}};
            partial_r <= 1'b0;
        end else if (clear) begin
            dur_r     <= {DUR_W{1'b0}};
            partial_r <= 1'b0;
        end else if (start) begin
            dur_r     <= DUR_ONE;
            partial_r <= start_partial;
        end else if (hold) begin
            dur_r     <= dur_inc_s;
            partial_r <= partial_r;
        end else begin
            dur_r     <= dur_r;
            partial_r <= partial_r;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the red/yellow/green lamp outputs of the traffic-light
// controller. Decodes the phase, checks one-hot lamps, phase order and
// (optionally) phase durations, captures the first error and counts cycles.
// Define TL_MON_DURATION_CHECK_EN to compile in the SHORT/LONG duration checks.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYC    = DEF_RED_CYC,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int GREEN_CYC  = DEF_GREEN_CYC,
    parameter int DUR_W      = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_red,
    input  logic        i_yellow,
    input  logic        i_green,
    input  logic        i_clr,
    output logic [1:0]  o_phase,
    output logic        o_err,
    output logic [2:0]  o_err_code,
    output logic        o_err_pulse,
    output logic        o_cycle_done,
    output logic [15:0] o_cycles
);

    // The duration counter must be able to reach the longest phase plus one.
    if ((RED_CYC >= (2 ** DUR_W) - 1) || (YELLOW_CYC >= (2 ** DUR_W) - 1) ||
        (GREEN_CYC >= (2 ** DUR_W) - 1)) begin : g_dur_w_check
        $error("traffic_light_monitor: DUR_W too narrow for the configured phase durations");
    end

    mon_state_e state_r, state_s;
    phase_e     phase_r, phase_s;
    phase_e     samp_s;
    logic       valid_s;
    err_code_e  err_s;
    logic       done_s;
    logic       short_s;
    logic       long_s;

    // Lamp decode: validity and the phase a valid sample represents.
    always_comb begin
        valid_s = lamps_onehot(i_red, i_yellow, i_green);
        if (i_red) begin
            samp_s = PH_RED;
        end else if (i_yellow) begin
            samp_s = PH_YELLOW;
        end else if (i_green) begin
            samp_s = PH_GREEN;
        end else begin
            samp_s = PH_NONE;
        end
    end

`ifdef TL_MON_DURATION_CHECK_EN
    logic [DUR_W-1:0] exp_s;
    logic             start_s;
    logic             start_partial_s;
    logic             hold_s;
    logic             clear_s;

    // Expected duration of the phase currently tracked, and timer controls.
    always_comb begin
        case (phase_r)
            PH_RED:    exp_s = DUR_W'(RED_CYC);
            PH_YELLOW: exp_s = DUR_W'(YELLOW_CYC);
            PH_GREEN:  exp_s = DUR_W'(GREEN_CYC);
            default:   exp_s = {DUR_W{1'b0}};
        endcase
        clear_s         = !valid_s;
        start_partial_s = valid_s && (state_r == ST_UNSYNC);
        start_s         = valid_s && ((state_r == ST_UNSYNC) || (samp_s != phase_r));
        hold_s          = valid_s && (state_r == ST_TRACK) && (samp_s == phase_r);
    end

    tl_phase_timer #(
        .DUR_W(DUR_W)
    ) u_phase_timer (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start_s),
        .start_partial(start_partial_s),
        .hold         (hold_s),
        .clear        (clear_s),
        .exp_cyc      (exp_s),
        .short_flag   (short_s),
        .long_flag    (long_s)
    );
`else
    assign short_s = 1'b0;
    assign long_s  = 1'b0;
`endif

    // Next state, next phase and the single prioritised error of this sample.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        err_s   = ERR_NONE;
        done_s  = 1'b0;
        if (!valid_s) begin
            err_s   = ERR_ONEHOT;
            state_s = ST_UNSYNC;
            phase_s = PH_NONE;
        end else begin
            case (state_r)
                ST_UNSYNC: begin
                    state_s = ST_TRACK;
                    phase_s = samp_s;
                end
                ST_TRACK: begin
                    if (samp_s == phase_r) begin
                        if (long_s) begin
                            err_s = ERR_LONG;
                        end else begin
                            err_s = ERR_NONE;
                        end
                    end else begin
                        phase_s = samp_s;
                        if (samp_s != next_phase(phase_r)) begin
                            err_s = ERR_ORDER;
                        end else begin
                            if (short_s) begin
                                err_s = ERR_SHORT;
                            end else begin
                                err_s = ERR_NONE;
                            end
                            done_s = (phase_r == PH_GREEN);
                        end
                    end
                end
                default: begin
                    state_s = ST_UNSYNC;
                    phase_s = PH_NONE;
                end
            endcase
        end
    end

    // State, phase, error capture and cycle counting registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= ST_UNSYNC;
            phase_r      <= PH_NONE;
            o_err        <= 1'b0;
            o_err_code   <= 3'd0;
            o_err_pulse  <= 1'b0;
            o_cycle_done <= 1'b0;
            o_cycles     <= 16'd0;
        end else begin
            state_r      <= state_s;
            phase_r      <= phase_s;
            o_err_pulse  <= (err_s != ERR_NONE);
            o_cycle_done <= done_s;
            if (done_s) begin
                o_cycles <= o_cycles + 16'd1;
            end else begin
                o_cycles <= o_cycles;
            end
            // First error wins; a clear in the same cycle lets the new one in.
            if ((err_s != ERR_NONE) && (!o_err || i_clr)) begin
                o_err      <= 1'b1;
                o_err_code <= err_s;
            end else if (i_clr) begin
                o_err      <= 1'b0;
                o_err_code <= 3'd0;
            end else begin
                o_err      <= o_err;
                o_err_code <= o_err_code;
            end
        end
    end

    assign o_phase = phase_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor. Each driven sample pushes the
// expected registered outputs to a scoreboard queue; a negedge monitor pops
// and compares them. Scenario tasks add their own inline checks.
module tb_traffic_light_monitor;

`ifdef TL_MON_DURATION_CHECK_EN
    localparam logic DUR_EN = 1'b1;
`else
    localparam logic DUR_EN = 1'b0;
`endif

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] SH = DUR_EN ? 3'd3 : 3'd0;
    localparam logic [2:0] LG = DUR_EN ? 3'd4 : 3'd0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_red = 1'b0, i_yellow = 1'b0, i_green = 1'b0, i_clr = 1'b0;
    logic [1:0]  o_phase;
    logic        o_err;
    logic [2:0]  o_err_code;
    logic        o_err_pulse;
    logic        o_cycle_done;
    logic [15:0] o_cycles;

    typedef struct {
        logic [1:0]  ph;
        logic        err;
        logic [2:0]  code;
        logic        pulse;
        logic        done;
        logic [15:0] cycles;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Bench-side record of sticky state implied by the stimulus.
    logic        m_err = 1'b0;
    logic [2:0]  m_code = 3'd0;
    logic [15:0] m_cycles = 16'd0;

    traffic_light_monitor dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_red       (i_red),
        .i_yellow    (i_yellow),
        .i_green     (i_green),
        .i_clr       (i_clr),
        .o_phase     (o_phase),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_err_pulse (o_err_pulse),
        .o_cycle_done(o_cycle_done),
        .o_cycles    (o_cycles)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compare registered outputs mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks = checks + 6;
            if (o_phase !== mon_e.ph) begin
                errors++; $display("FAIL sb_phase t=%0t got %0d want %0d", $time, o_phase, mon_e.ph);
            end
            if (o_err !== mon_e.err) begin
                errors++; $display("FAIL sb_err t=%0t got %0b want %0b", $time, o_err, mon_e.err);
            end
            if (o_err_code !== mon_e.code) begin
                errors++; $display("FAIL sb_code t=%0t got %0d want %0d", $time, o_err_code, mon_e.code);
            end
            if (o_err_pulse !== mon_e.pulse) begin
                errors++; $display("FAIL sb_pulse t=%0t got %0b want %0b", $time, o_err_pulse, mon_e.pulse);
            end
            if (o_cycle_done !== mon_e.done) begin
                errors++; $display("FAIL sb_done t=%0t got %0b want %0b", $time, o_cycle_done, mon_e.done);
            end
            if (o_cycles !== mon_e.cycles) begin
                errors++; $display("FAIL sb_cycles t=%0t got %0d want %0d", $time, o_cycles, mon_e.cycles);
            end
        end
    end

    // Drive one lamp sample, push its expected outcome, advance one cycle.
    task automatic step(input logic [2:0] rgy, input logic clr, input logic [1:0] ph,
                        input logic [2:0] raised, input logic done);
        exp_t e;
        i_red = rgy[2]; i_yellow = rgy[1]; i_green = rgy[0]; i_clr = clr;
        if (!rstn) begin
            m_err = 1'b0; m_code = 3'd0; m_cycles = 16'd0;
            e.ph = 2'd3; e.pulse = 1'b0; e.done = 1'b0;
        end else begin
            if ((raised != 3'd0) && (!m_err || clr)) begin
                m_err = 1'b1; m_code = raised;
            end else if (clr) begin
                m_err = 1'b0; m_code = 3'd0;
            end
            if (done) m_cycles = m_cycles + 16'd1;
            e.ph = ph; e.pulse = (raised != 3'd0); e.done = done;
        end
        e.err = m_err; e.code = m_code; e.cycles = m_cycles;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Hold one lamp for n error-free samples.
    task automatic run(input logic [2:0] rgy, input int n, input logic [1:0] ph);
        for (int i = 0; i < n; i++) step(rgy, 1'b0, ph, 3'd0, 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step(R, 1'b0, 2'd3, 3'd0, 1'b0);
        step(G, 1'b1, 2'd3, 3'd0, 1'b0);
        checks++;
        if (o_phase !== 2'd3 || o_err !== 1'b0 || o_cycles !== 16'd0) begin
            errors++; $display("FAIL reset got ph=%0d err=%0b cyc=%0d want ph=3 err=0 cyc=0", o_phase, o_err, o_cycles);
        end
        rstn = 1'b1;
    endtask

    task automatic test_legal();
        run(R, 30, 2'd0);
        run(Y, 5, 2'd1);
        run(G, 20, 2'd2);
        step(R, 1'b0, 2'd0, 3'd0, 1'b1);
        run(R, 29, 2'd0);
        checks++;
        if (o_cycles !== 16'd1 || o_err !== 1'b0) begin
            errors++; $display("FAIL legal got cyc=%0d err=%0b want cyc=1 err=0", o_cycles, o_err);
        end
    endtask

    task automatic test_short();
        run(Y, 4, 2'd1);
        step(G, 1'b0, 2'd2, SH, 1'b0);
        checks++;
        if (o_err_code !== SH || o_phase !== 2'd2 || o_err_pulse !== DUR_EN) begin
            errors++; $display("FAIL short got code=%0d ph=%0d pulse=%0b want code=%0d ph=2 pulse=%0b",
                               o_err_code, o_phase, o_err_pulse, SH, DUR_EN);
        end
    endtask

    task automatic test_long();
        step(G, 1'b1, 2'd2, 3'd0, 1'b0);
        run(G, 18, 2'd2);
        step(G, 1'b0, 2'd2, LG, 1'b0);
        checks++;
        if (o_err_code !== LG || o_err_pulse !== DUR_EN) begin
            errors++; $display("FAIL long got code=%0d pulse=%0b want code=%0d pulse=%0b",
                               o_err_code, o_err_pulse, LG, DUR_EN);
        end
        run(G, 2, 2'd2);
        step(R, 1'b0, 2'd0, 3'd0, 1'b1);
        checks++;
        if (o_cycles !== 16'd2) begin
            errors++; $display("FAIL long_cycles got %0d want 2", o_cycles);
        end
    endtask

    task automatic test_order_onehot();
        step(R, 1'b1, 2'd0, 3'd0, 1'b0);
        step(G, 1'b0, 2'd2, 3'd2, 1'b0);
        checks++;
        if (o_err_code !== 3'd2 || o_cycles !== 16'd2) begin
            errors++; $display("FAIL order got code=%0d cyc=%0d want code=2 cyc=2", o_err_code, o_cycles);
        end
        step(G, 1'b1, 2'd2, 3'd0, 1'b0);
        step(3'b101, 1'b0, 2'd3, 3'd1, 1'b0);
        checks++;
        if (o_err_code !== 3'd1 || o_phase !== 2'd3) begin
            errors++; $display("FAIL onehot got code=%0d ph=%0d want code=1 ph=3", o_err_code, o_phase);
        end
        step(3'b000, 1'b0, 2'd3, 3'd1, 1'b0);
        step(Y, 1'b0, 2'd1, 3'd0, 1'b0);
    endtask

    task automatic test_clr_collision_reset();
        step(G, 1'b0, 2'd2, 3'd0, 1'b0);
        step(Y, 1'b1, 2'd1, 3'd2, 1'b0);
        checks++;
        if (o_err !== 1'b1 || o_err_code !== 3'd2) begin
            errors++; $display("FAIL clr_collision got err=%0b code=%0d want err=1 code=2", o_err, o_err_code);
        end
        run(Y, 4, 2'd1);
        run(G, 20, 2'd2);
        step(R, 1'b0, 2'd0, 3'd0, 1'b1);
        run(R, 9, 2'd0);
        rstn = 1'b0;
        step(R, 1'b0, 2'd3, 3'd0, 1'b0);
        checks++;
        if (o_phase !== 2'd3 || o_err !== 1'b0 || o_err_code !== 3'd0 || o_cycles !== 16'd0 ||
            o_err_pulse !== 1'b0 || o_cycle_done !== 1'b0) begin
            errors++; $display("FAIL mid_reset got ph=%0d err=%0b code=%0d cyc=%0d want 3/0/0/0",
                               o_phase, o_err, o_err_code, o_cycles);
        end
        rstn = 1'b1;
        run(R, 3, 2'd0);
        run(Y, 5, 2'd1);
        step(G, 1'b0, 2'd2, 3'd0, 1'b0);
        checks++;
        if (o_err !== 1'b0) begin
            errors++; $display("FAIL partial_after_reset got err=%0b code=%0d want err=0", o_err, o_err_code);
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_short();
        test_long();
        test_order_onehot();
        test_clr_collision_reset();
        for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
